// File: rtl/ccd_line_scheduler.sv
// ccd_line_scheduler: issues CCD line triggers at a programmable period, counts lines per frame,
// throttles on backpressure and flags readout overruns. Define SCHED_STATS_EN for stall/frame counters.
module ccd_line_scheduler #(
  parameter int                  PERIOD_W   = 25,
  parameter int                  ROWS_W     = 11,
  parameter logic [PERIOD_W-1:0] MIN_PERIOD = 25'd2200,
  parameter int                  TRIG_W     = 4
) (
  input  logic                pxl_clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                continuous_i,
  input  logic [PERIOD_W-1:0] line_period_i,
  input  logic [ROWS_W-1:0]   rows_i,
  input  logic                sink_ready_i,
  input  logic                line_busy_i,
  output logic                line_trigger_o,
  output logic                frame_start_o,
  output logic                frame_done_o,
  output logic                busy_o,
  output logic [ROWS_W-1:0]   line_idx_o,
  output logic                err_overrun_o
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]         stall_cnt_o,
  output logic [15:0]         frame_cnt_o
`endif
);

  localparam int TC_W = (TRIG_W > 1) ? $clog2(TRIG_W) : 1;
  localparam logic [PERIOD_W-1:0] TRIG_FLOOR   = PERIOD_W'(TRIG_W + 1);
  localparam logic [PERIOD_W-1:0] PERIOD_FLOOR = (MIN_PERIOD > TRIG_FLOOR) ? MIN_PERIOD : TRIG_FLOOR;

  typedef enum logic [2:0] {IDLE, ARM, WAIT_RDY, FIRE, WAIT_PER, DRAIN, DONE} state_e;

  state_e              state_q;
  logic [PERIOD_W-1:0] per_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic [ROWS_W-1:0]   rows_q;
  logic [ROWS_W-1:0]   line_idx_q;
  logic [TC_W-1:0]     tcnt_q;
  logic                trig_q;
  logic                fstart_q;
  logic                fdone_q;
  logic                busy_q;
  logic                err_q;
  logic                stop_pend_q;

  logic [PERIOD_W-1:0] eff_period;
  logic                path_ready;
  logic                expired;
  logic                stop_now;
  logic                last_line;

  assign eff_period = (line_period_i < PERIOD_FLOOR) ? PERIOD_FLOOR : line_period_i;
  assign path_ready = sink_ready_i & ~line_busy_i;
  // Only lines after the first have a running period that can expire.
  assign expired    = (cnt_q == '0) && (line_idx_q != '0);
  assign stop_now   = stop_pend_q | stop_i;
  assign last_line  = (line_idx_q == rows_q - ROWS_W'(1));

  // The period counter free-runs down to 0 and saturates; a FIRE entry reloads it.
  always_ff @(posedge pxl_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      per_q       <= '0;
      cnt_q       <= '0;
      rows_q      <= '0;
      line_idx_q  <= '0;
      tcnt_q      <= '0;
      trig_q      <= 1'b0;
      fstart_q    <= 1'b0;
      fdone_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      fstart_q <= 1'b0;
      fdone_q  <= 1'b0;
      if (cnt_q != '0) cnt_q <= cnt_q - PERIOD_W'(1);
      if (stop_i && state_q != IDLE) stop_pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q     <= ARM;
            busy_q      <= 1'b1;
            rows_q      <= rows_i;
            per_q       <= eff_period;
            err_q       <= 1'b0;
            stop_pend_q <= stop_i;
          end
        end
        ARM: begin
          line_idx_q <= '0;
          if (rows_q == '0) begin
            state_q <= DONE;
            fdone_q <= 1'b1;
          end else begin
            state_q <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (expired && line_busy_i) err_q <= 1'b1;
          if (path_ready) begin
            state_q  <= FIRE;
            trig_q   <= 1'b1;
            tcnt_q   <= TC_W'(TRIG_W - 1);
            cnt_q    <= per_q - PERIOD_W'(1);
            fstart_q <= (line_idx_q == '0);
          end
        end
        FIRE: begin
          if (tcnt_q == '0) begin
            trig_q  <= 1'b0;
            state_q <= WAIT_PER;
          end else begin
            tcnt_q <= tcnt_q - TC_W'(1);
          end
        end
        WAIT_PER: begin
          if (cnt_q == '0) begin
            if (last_line || stop_now) begin
              state_q <= DRAIN;
            end else begin
              line_idx_q <= line_idx_q + ROWS_W'(1);
              // Firing straight from here keeps trigger spacing at exactly eff_period.
              if (path_ready) begin
                state_q <= FIRE;
                trig_q  <= 1'b1;
                tcnt_q  <= TC_W'(TRIG_W - 1);
                cnt_q   <= per_q - PERIOD_W'(1);
              end else begin
                state_q <= WAIT_RDY;
              end
            end
          end
        end
        DRAIN: begin
          // A seen falling edge and two low cycles both leave line_busy low now.
          if (!line_busy_i) begin
            state_q <= DONE;
            fdone_q <= 1'b1;
          end
        end
        DONE: begin
          if (continuous_i && !stop_now) begin
            state_q <= ARM;
            rows_q  <= rows_i;
            per_q   <= eff_period;
          end else begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            stop_pend_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign line_trigger_o = trig_q;
  assign frame_start_o  = fstart_q;
  assign frame_done_o   = fdone_q;
  assign busy_o         = busy_q;
  assign line_idx_o     = line_idx_q;
  assign err_overrun_o  = err_q;

`ifdef SCHED_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] frame_cnt_q;

  always_ff @(posedge pxl_clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (state_q == WAIT_RDY && !sink_ready_i && expired && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (fdone_q) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_ccd_line_scheduler.sv
// Testbench for ccd_line_scheduler: vector table of single frames plus continuous, backpressure,
// overrun and mid-frame reset sequences.
module tb_ccd_line_scheduler;

  logic        pxl_clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        continuous;
  logic [24:0] line_period;
  logic [10:0] rows;
  logic        sink_ready;
  logic        line_busy;
  logic        line_trigger_o;
  logic        frame_start_o;
  logic        frame_done_o;
  logic        busy_o;
  logic [10:0] line_idx_o;
  logic        err_overrun_o;
`ifdef SCHED_STATS_EN
  logic [15:0] stall_cnt_o;
  logic [15:0] frame_cnt_o;
`endif

  ccd_line_scheduler dut (
    .pxl_clk_i      (pxl_clk),
    .rst_i          (rst),
    .start_i        (start),
    .stop_i         (stop),
    .continuous_i   (continuous),
    .line_period_i  (line_period),
    .rows_i         (rows),
    .sink_ready_i   (sink_ready),
    .line_busy_i    (line_busy),
    .line_trigger_o (line_trigger_o),
    .frame_start_o  (frame_start_o),
    .frame_done_o   (frame_done_o),
    .busy_o         (busy_o),
    .line_idx_o     (line_idx_o),
    .err_overrun_o  (err_overrun_o)
`ifdef SCHED_STATS_EN
    ,
    .stall_cnt_o    (stall_cnt_o),
    .frame_cnt_o    (frame_cnt_o)
`endif
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busyLen = 1500;
  int startCyc = 0;

  int trigCnt, firstTrig, lastTrig, minGap, maxGap;
  int fsCnt, fsBad, fdCnt, fdCyc, lastFall;
  bit trigPrev = 1'b0;
  bit busyPrev = 1'b0;

  typedef struct {
    int rows;
    int period;
    bit stopAtStart;
    int expTrig;
    int expGap;
    int expFs;
  } vec_t;
  vec_t vecs[6];

  initial begin
    pxl_clk = 1'b0;
    forever #5 pxl_clk = ~pxl_clk;
  end

  initial forever begin
    @(posedge pxl_clk);
    cyc <= cyc + 1;
  end

  // Readout model: line_busy rises 2 cycles after each trigger and stays up busyLen cycles.
  initial begin
    line_busy = 1'b0;
    forever begin
      @(posedge line_trigger_o);
      repeat (2) @(posedge pxl_clk);
      #1 line_busy = 1'b1;
      repeat (busyLen) @(posedge pxl_clk);
      #1 line_busy = 1'b0;
    end
  end

  // Output monitor sampled on the falling edge.
  initial forever begin
    @(negedge pxl_clk);
    if (line_trigger_o && !trigPrev) begin
      if (trigCnt > 0) begin
        if (cyc - lastTrig < minGap) minGap = cyc - lastTrig;
        if (cyc - lastTrig > maxGap) maxGap = cyc - lastTrig;
      end else begin
        firstTrig = cyc;
      end
      lastTrig = cyc;
      trigCnt++;
    end
    if (frame_start_o) begin
      fsCnt++;
      if (!(line_trigger_o && !trigPrev)) fsBad++;
    end
    if (frame_done_o) begin
      fdCnt++;
      fdCyc = cyc;
    end
    if (!line_busy && busyPrev) lastFall = cyc;
    trigPrev = line_trigger_o;
    busyPrev = line_busy;
  end

  task automatic tick();
    @(negedge pxl_clk);
    #1;
  endtask

  task automatic clearMon();
    trigCnt = 0; firstTrig = -1; lastTrig = -1;
    minGap = 1 << 30; maxGap = 0;
    fsCnt = 0; fsBad = 0; fdCnt = 0; fdCyc = -1; lastFall = -1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, wanted %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input int r, input int period, input bit cont, input bit withStop);
    rows        = r[10:0];
    line_period = period[24:0];
    continuous  = cont;
    start       = 1'b1;
    stop        = withStop;
    startCyc    = cyc;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    tick();
    tick();
    while (busy_o && n < budget) begin
      tick();
      n++;
    end
    if (busy_o) checkOutput("idleTimeout", 1, 0);
  endtask

  task automatic waitTrig(input int target, input int budget);
    int n = 0;
    while (trigCnt < target && n < budget) begin
      tick();
      n++;
    end
    if (trigCnt < target) checkOutput("trigTimeout", trigCnt, target);
  endtask

  initial begin
    int fdSnap, fallSnap, relCyc, t1, gap;

    vecs[0] = '{rows: 3, period: 3000, stopAtStart: 1'b0, expTrig: 3, expGap: 3000, expFs: 1};
    vecs[1] = '{rows: 2, period: 100,  stopAtStart: 1'b0, expTrig: 2, expGap: 2200, expFs: 1};
    vecs[2] = '{rows: 3, period: 2201, stopAtStart: 1'b0, expTrig: 3, expGap: 2201, expFs: 1};
    vecs[3] = '{rows: 1, period: 2500, stopAtStart: 1'b0, expTrig: 1, expGap: 0,    expFs: 1};
    vecs[4] = '{rows: 0, period: 3000, stopAtStart: 1'b0, expTrig: 0, expGap: 0,    expFs: 0};
    vecs[5] = '{rows: 3, period: 3000, stopAtStart: 1'b1, expTrig: 1, expGap: 0,    expFs: 1};

    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    line_period = '0; rows = '0; sink_ready = 1'b1;
    clearMon();
    repeat (3) tick();
    checkOutput("rstTrigger", line_trigger_o, 0);
    checkOutput("rstFrameStart", frame_start_o, 0);
    checkOutput("rstFrameDone", frame_done_o, 0);
    checkOutput("rstBusy", busy_o, 0);
    checkOutput("rstLineIdx", line_idx_o, 0);
    checkOutput("rstErr", err_overrun_o, 0);
    rst = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 6; i++) begin
      $display("[TB] vector %0d: rows=%0d period=%0d", i, vecs[i].rows, vecs[i].period);
      clearMon();
      applyStimulus(vecs[i].rows, vecs[i].period, 1'b0, vecs[i].stopAtStart);
      waitIdle(20000);
      checkOutput("trigCount", trigCnt, vecs[i].expTrig);
      if (vecs[i].expTrig >= 2) begin
        checkOutput("minGap", minGap, vecs[i].expGap);
        checkOutput("maxGap", maxGap, vecs[i].expGap);
      end
      checkOutput("frameStartCount", fsCnt, vecs[i].expFs);
      checkOutput("frameStartAligned", fsBad, 0);
      checkOutput("frameDoneCount", fdCnt, 1);
      if (vecs[i].expTrig > 0) checkOutput("doneAfterFall", int'(fdCyc > lastFall), 1);
      if (vecs[i].rows == 0) checkOutput("emptyDoneLatency", fdCyc - startCyc, 2);
      checkOutput("errClear", err_overrun_o, 0);
      checkOutput("busyIdle", busy_o, 0);
      repeat (5) tick();
    end

    $display("[TB] continuous frames with stop in frame 3");
    clearMon();
    applyStimulus(2, 100, 1'b1, 1'b0);
    waitTrig(6, 20000);
    fdSnap = fdCnt;
    checkOutput("contDoneBeforeStop", fdSnap, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    waitIdle(20000);
    continuous = 1'b0;
    checkOutput("contDoneCount", fdCnt, 3);
    checkOutput("contTrigCount", trigCnt, 6);
    checkOutput("contFrameStarts", fsCnt, 3);
    checkOutput("contFsAligned", fsBad, 0);
    repeat (3000) tick();
    checkOutput("contNoRestart", trigCnt, 6);
    checkOutput("contBusyIdle", busy_o, 0);

    $display("[TB] backpressure after first line");
    clearMon();
    applyStimulus(2, 3000, 1'b0, 1'b0);
    waitTrig(1, 100);
    sink_ready = 1'b0;
    t1 = lastTrig;
    repeat (5000) tick();
    sink_ready = 1'b1;
    relCyc = cyc;
    waitIdle(20000);
    checkOutput("bpTrigCount", trigCnt, 2);
    checkOutput("bpReleaseLatency", lastTrig - relCyc, 1);
    checkOutput("bpGapLonger", int'(lastTrig - t1 > 3000), 1);
    checkOutput("bpNoOverrun", err_overrun_o, 0);
`ifdef SCHED_STATS_EN
    checkOutput("bpStallCnt", int'(stall_cnt_o > 0), 1);
`endif
    repeat (5) tick();

    $display("[TB] readout overrun");
    clearMon();
    busyLen = 3000;
    applyStimulus(2, 2200, 1'b0, 1'b0);
    waitTrig(2, 20000);
    fallSnap = lastFall;
    gap = lastTrig - firstTrig;
    checkOutput("ovrErrSet", err_overrun_o, 1);
    checkOutput("ovrWaitsForFall", int'(fallSnap > firstTrig && lastTrig > fallSnap), 1);
    checkOutput("ovrGapLonger", int'(gap > 2200), 1);
    waitIdle(20000);
    checkOutput("ovrErrSticky", err_overrun_o, 1);
    busyLen = 1500;
    repeat (5) tick();
    clearMon();
    applyStimulus(0, 3000, 1'b0, 1'b0);
    checkOutput("ovrErrClearedByStart", err_overrun_o, 0);
    waitIdle(100);

    $display("[TB] reset during FIRE");
    clearMon();
    applyStimulus(2, 3000, 1'b0, 1'b0);
    waitTrig(1, 100);
    checkOutput("rstMidTrigHigh", line_trigger_o, 1);
    rst = 1'b1;
    #1;
    checkOutput("rstMidTrigDrop", line_trigger_o, 0);
    checkOutput("rstMidBusyDrop", busy_o, 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (50) tick();
    checkOutput("rstMidNoDone", fdCnt, 0);
    checkOutput("rstMidIdle", busy_o, 0);
    checkOutput("rstMidTrigCount", trigCnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
